// File: rtl/mem_io_ctrl.sv
// CPU-side memory/IO controller: decodes each request to an async SRAM access,
// a UART data register access or a UART status read, and sequences the strobes.
module mem_io_ctrl #(
  parameter int              DATA_W         = 16,
  parameter int              ADDR_W         = 16,
  parameter int              RAM_ADDR_W     = 18,
  parameter int              WAIT_CYC       = 2,
  parameter logic [ADDR_W-1:0] UART_DATA_ADDR = 16'hBF00,
  parameter logic [ADDR_W-1:0] UART_STAT_ADDR = 16'hBF01
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic                  req_we,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  req_ready,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  ram_en_n,
  output logic                  ram_oe_n,
  output logic                  ram_we_n,
  output logic [RAM_ADDR_W-1:0] ram_addr,
  inout  wire  [DATA_W-1:0]     ram_data,
  input  logic                  tbre,
  input  logic                  tsre,
  input  logic                  data_ready,
  output logic                  rdn,
  output logic                  wrn
);

  typedef enum logic [3:0] {
    IDLE, RAM_RD, RAM_WR_SETUP, RAM_WR, UART_RD, UART_WR_WAIT, UART_WR, STAT, DONE
  } state_t;

  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYC - 1);

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                drive_data;
  logic                ram_target;
  logic                counting;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
    end
  end

  assign ram_target = (addr_q != UART_DATA_ADDR) && (addr_q != UART_STAT_ADDR);
  assign counting   = (state_q == RAM_RD) || (state_q == RAM_WR) ||
                      (state_q == UART_RD) || (state_q == UART_WR);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          we_d    = req_we;
          if (req_addr == UART_DATA_ADDR)      state_d = req_we ? UART_WR_WAIT : UART_RD;
          else if (req_addr == UART_STAT_ADDR) state_d = req_we ? DONE : STAT;
          else                                 state_d = req_we ? RAM_WR_SETUP : RAM_RD;
        end
      end
      RAM_RD: begin
        if (cnt_q == LAST_CNT) begin
          rdata_d = ram_data;
          state_d = DONE;
        end
      end
      RAM_WR_SETUP: state_d = RAM_WR;
      RAM_WR:       if (cnt_q == LAST_CNT) state_d = DONE;
      UART_RD: begin
        if (cnt_q == LAST_CNT) begin
          rdata_d = {{(DATA_W-8){1'b0}}, ram_data[7:0]};
          state_d = DONE;
        end
      end
      UART_WR_WAIT: if (tbre && tsre) state_d = UART_WR;
      UART_WR:      if (cnt_q == LAST_CNT) state_d = DONE;
      STAT: begin
        rdata_d = {{(DATA_W-2){1'b0}}, data_ready, tbre && tsre};
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Counter restarts on every state entry and saturates rather than wrapping.
    if (state_d != state_q)                cnt_d = '0;
    else if (counting && cnt_q != 4'hF)    cnt_d = cnt_q + 4'd1;
    else                                   cnt_d = cnt_q;
  end

  always_comb begin
    ram_en_n   = 1'b1;
    ram_oe_n   = 1'b1;
    ram_we_n   = 1'b1;
    rdn        = 1'b1;
    wrn        = 1'b1;
    drive_data = 1'b0;
    case (state_q)
      RAM_RD:       begin ram_en_n = 1'b0; ram_oe_n = 1'b0; end
      RAM_WR_SETUP: begin ram_en_n = 1'b0; drive_data = 1'b1; end
      RAM_WR:       begin ram_en_n = 1'b0; ram_we_n = 1'b0; drive_data = 1'b1; end
      UART_RD:      rdn = 1'b0;
      UART_WR:      begin wrn = 1'b0; drive_data = 1'b1; end
      // Write data is held one cycle past the rising we_n edge for SRAM hold time.
      DONE:         drive_data = we_q && ram_target;
      default:      ;
    endcase
  end

  assign ram_data  = drive_data ? wdata_q : {DATA_W{1'bz}};
  assign ram_addr  = RAM_ADDR_W'(addr_q);
  assign req_ready = (state_q == IDLE) && !rst;
  assign rsp_valid = (state_q == DONE);
  assign rsp_rdata = rdata_q;

endmodule
